non_restoring_divider_mc: RTL and testbench
===========================================

NON_RESTORING_DIVIDER_MC -- requirements
Module: non_restoring_divider_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand and result width; it SHALL be a power of 2 and at least 8.
REQ-002 Parameter BITS_PER_CYCLE, default 2, SHALL set the quotient bits retired per DIVIDE cycle; legal values are 1, 2 and 4, and it SHALL divide DATA_WIDTH.
REQ-003 clk_i  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 clk_en_i  in  1  SHALL be the clock enable; when low, all state SHALL hold.
REQ-006 dividend_i, divisor_i  in  DATA_WIDTH  SHALL be the operands.
REQ-007 signed_i  in  1  SHALL select two's-complement division when 1 and unsigned division when 0.
REQ-008 data_valid_i  in  1  SHALL request a division.
REQ-009 ready_o  out  1  SHALL be high exactly when the FSM is in IDLE.
REQ-010 quotient_o, remainder_o  out  DATA_WIDTH  SHALL be the registered results.
REQ-011 divide_by_zero_o, overflow_o, data_valid_o  out  1 each  SHALL be registered status outputs.

Function
REQ-012 The FSM SHALL have three states: IDLE, DIVIDE and RESTORE.
REQ-013 An operation SHALL be accepted on a clk_en_i edge only when data_valid_i=1 and the state is IDLE; data_valid_i SHALL be ignored in every other state.
REQ-014 On acceptance the block SHALL latch the operand magnitudes, the quotient sign and the remainder sign (sign of dividend) and the mode, then enter DIVIDE.
- Operands SHALL be sampled only on the acceptance edge.
REQ-015 In DIVIDE the block SHALL perform BITS_PER_CYCLE chained non-restoring steps per cycle.
- Remainder register SHALL be DATA_WIDTH+1 bits.
- Each step: add the divisor if the partial remainder is negative, otherwise subtract it; shift in the inverted sign as the quotient bit.
REQ-016 DIVIDE SHALL last exactly DATA_WIDTH/BITS_PER_CYCLE cycles, counted by an iteration counter of width $clog2(DATA_WIDTH/BITS_PER_CYCLE)+1, and SHALL then enter RESTORE.
REQ-017 In RESTORE the block SHALL perform the following, then return to IDLE:
- add the divisor to a negative remainder;
- apply the sign corrections (negate the quotient if the quotient sign is 1; negate the remainder if the dividend was negative);
- register the results.
REQ-018 data_valid_o SHALL be high for exactly one cycle, the cycle after RESTORE.
- Latency from the acceptance edge to data_valid_o high SHALL be DATA_WIDTH/BITS_PER_CYCLE+2 cycles.
- A new operation SHALL be acceptable in that same cycle.
REQ-019 quotient_o, remainder_o, divide_by_zero_o and overflow_o SHALL hold their values until the next RESTORE or reset.
REQ-020 Divisor zero SHALL skip DIVIDE (IDLE->RESTORE) and SHALL produce quotient all-ones, remainder = dividend and divide_by_zero_o=1, with a latency of 2 cycles.
REQ-021 Signed mode with dividend = most negative value and divisor = -1 SHALL skip DIVIDE and SHALL produce quotient = dividend, remainder 0 and overflow_o=1, with a latency of 2 cycles.
REQ-022 The remainder SHALL always satisfy |remainder| < |divisor| and dividend = quotient*divisor + remainder (modulo 2^DATA_WIDTH).

Reset
REQ-023 While rst_i=1 at a clock edge, regardless of clk_en_i, the block SHALL do the following, including mid-operation (the aborted result is discarded):
- enter IDLE;
- clear the counter;
- clear all outputs: quotient_o=0, remainder_o=0, divide_by_zero_o=0, overflow_o=0, data_valid_o=0, ready_o=1 after reset.

Configuration
REQ-024 With macro NR_DIVIDER_SIGNED_EN defined, signed_i, the operand absolute-value logic, the sign correction and overflow detection SHALL be compiled in.
REQ-025 Without NR_DIVIDER_SIGNED_EN, signed_i SHALL be ignored (all operations unsigned) and overflow_o SHALL be tied to 0.

Structure
REQ-026 The fsm_state_t enum and the partial-result struct {rem_sign, remainder, quotient} SHALL reside in the shared package divider_pkg.
REQ-027 One combinational sub-module nr_div_step SHALL implement a single radix-2 non-restoring step; it SHALL be instantiated BITS_PER_CYCLE times in a generate chain.

Verification (DATA_WIDTH=16, BITS_PER_CYCLE=2, latency 10)
REQ-028 Unsigned 100/7 -> quotient 14, remainder 2, data_valid_o high exactly 10 cycles after acceptance.
REQ-029 Signed -100/7 (0xFF9C/0x0007) -> quotient 0xFFF2, remainder 0xFFFE; the same operands with NR_DIVIDER_SIGNED_EN undefined -> quotient 9348, remainder 0.
REQ-030 1234/0 -> quotient 0xFFFF, remainder 1234, divide_by_zero_o=1, latency 2; signed 0x8000/0xFFFF -> quotient 0x8000, remainder 0, overflow_o=1, latency 2.
REQ-031 rst_i asserted in DIVIDE cycle 4 -> next cycle IDLE, ready_o=1, all outputs 0, no data_valid_o pulse.
REQ-032 data_valid_i held high continuously with changing operands -> back-to-back results every 10 cycles, operands sampled only at acceptance edges, clk_en_i low for 3 cycles extends latency by exactly 3.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types for the multi-cycle non-restoring divider.
// DIV_MAX_W bounds DATA_WIDTH; narrower instances use the low bits of each field.
package divider_pkg;

    localparam int DIV_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVIDE  = 2'd1,
        RESTORE = 2'd2
    } fsm_state_t;

    // {rem_sign, remainder} is the DATA_WIDTH+1-bit partial remainder;
    // quotient shifts dividend bits out of the top and quotient bits in at the bottom.
    typedef struct packed {
        logic                 rem_sign;
        logic [DIV_MAX_W-1:0] remainder;
        logic [DIV_MAX_W-1:0] quotient;
    } part_res_t;

endpackage

// File: rtl/nr_div_step.sv
// One radix-2 non-restoring division step (combinational).
module nr_div_step
    import divider_pkg::*;
#(
    parameter int W = 32
) (
    input  part_res_t      part_i,
    input  logic [W-1:0]   divisor_i,
    output part_res_t      part_o
);

    logic [W:0] shifted;
    logic [W:0] next_rem;

    always_comb begin
        shifted  = {part_i.remainder[W-1:0], part_i.quotient[W-1]};
        next_rem = part_i.rem_sign ? shifted + {1'b0, divisor_i}
                                   : shifted - {1'b0, divisor_i};
        // Upper (unused-width) bits pass through unchanged.
        part_o                    = part_i;
        part_o.rem_sign           = next_rem[W];
        part_o.remainder[W-1:0]   = next_rem[W-1:0];
        part_o.quotient[W-1:0]    = {part_i.quotient[W-2:0], ~next_rem[W]};
    end

endmodule

// File: rtl/non_restoring_divider_mc.sv
// Multi-cycle non-restoring divider retiring BITS_PER_CYCLE quotient bits per cycle.
// Define NR_DIVIDER_SIGNED_EN to build in two's-complement support and overflow detection.
module non_restoring_divider_mc
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_en_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  signed_i,
    input  logic                  data_valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o,
    output logic                  overflow_o,
    output logic                  data_valid_o
);

    localparam int W     = DATA_WIDTH;
    localparam int ITERS = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS) + 1;

    if (DATA_WIDTH < 8 || DATA_WIDTH > DIV_MAX_W || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 ||
        !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("non_restoring_divider_mc: unsupported DATA_WIDTH/BITS_PER_CYCLE");
    end

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    part_res_t        part_q, part_d;
    logic [W-1:0]     divisor_q, divisor_d;
    logic             spec_dbz_q, spec_dbz_d;
    logic             spec_ovf_q, spec_ovf_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [W-1:0]     quotient_q, quotient_d;
    logic [W-1:0]     remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [W-1:0]     dvd_mag, dvs_mag;
    logic             dvd_neg, dvs_neg, is_ovf;
    logic [W-1:0]     rem_fix, quot_fin, rem_fin;

`ifdef NR_DIVIDER_SIGNED_EN
    assign dvd_neg = signed_i & dividend_i[W-1];
    assign dvs_neg = signed_i & divisor_i[W-1];
    assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_mag = dvs_neg ? -divisor_i  : divisor_i;
    assign is_ovf  = signed_i && (dividend_i == {1'b1, {(W-1){1'b0}}}) && (&divisor_i);
    assign quot_fin = q_neg_q ? -part_q.quotient[W-1:0] : part_q.quotient[W-1:0];
    assign rem_fin  = r_neg_q ? -rem_fix : rem_fix;
`else
    logic unused_signed;
    assign unused_signed = signed_i;
    assign dvd_neg  = 1'b0;
    assign dvs_neg  = 1'b0;
    assign dvd_mag  = dividend_i;
    assign dvs_mag  = divisor_i;
    assign is_ovf   = 1'b0;
    assign quot_fin = part_q.quotient[W-1:0];
    assign rem_fin  = rem_fix;
`endif

    // The final remainder lies in [0, divisor), so W bits suffice for the correction add.
    assign rem_fix = part_q.remainder[W-1:0] + (part_q.rem_sign ? divisor_q : '0);

    part_res_t chain [BITS_PER_CYCLE+1];
    assign chain[0] = part_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        nr_div_step #(.W(W)) u_step (
            .part_i    (chain[g]),
            .divisor_i (divisor_q),
            .part_o    (chain[g+1])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        part_d      = part_q;
        divisor_d   = divisor_q;
        spec_dbz_d  = spec_dbz_q;
        spec_ovf_d  = spec_ovf_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        valid_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (data_valid_i) begin
                    part_d     = '0;
                    // Special cases keep the raw dividend; it is returned unchanged.
                    part_d.quotient[W-1:0] = (divisor_i == '0 || is_ovf) ? dividend_i : dvd_mag;
                    divisor_d  = dvs_mag;
                    q_neg_d    = dvd_neg ^ dvs_neg;
                    r_neg_d    = dvd_neg;
                    spec_dbz_d = (divisor_i == '0);
                    spec_ovf_d = is_ovf && (divisor_i != '0);
                    cnt_d      = '0;
                    state_d    = (divisor_i == '0 || is_ovf) ? RESTORE : DIVIDE;
                end
            end
            DIVIDE: begin
                part_d = chain[BITS_PER_CYCLE];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                dbz_d   = spec_dbz_q;
                ovf_d   = spec_ovf_q;
                valid_d = 1'b1;
                state_d = IDLE;
                if (spec_dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = part_q.quotient[W-1:0];
                end else if (spec_ovf_q) begin
                    quotient_d  = part_q.quotient[W-1:0];
                    remainder_d = '0;
                end else begin
                    quotient_d  = quot_fin;
                    remainder_d = rem_fin;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            part_q      <= '0;
            divisor_q   <= '0;
            spec_dbz_q  <= 1'b0;
            spec_ovf_q  <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else if (clk_en_i) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            part_q      <= part_d;
            divisor_q   <= divisor_d;
            spec_dbz_q  <= spec_dbz_d;
            spec_ovf_q  <= spec_ovf_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
        end
    end

    assign ready_o          = (state_q == IDLE);
    assign quotient_o       = quotient_q;
    assign remainder_o      = remainder_q;
    assign divide_by_zero_o = dbz_q;
    assign overflow_o       = ovf_q;
    assign data_valid_o     = valid_q;

endmodule

// File: tb/tb_non_restoring_divider_mc.sv
// Scoreboard bench for non_restoring_divider_mc at DATA_WIDTH=16, BITS_PER_CYCLE=2.
// Latency counts clock edges from the acceptance edge (inclusive) to the edge raising data_valid_o.
module tb_non_restoring_divider_mc;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        clk_en_i = 1'b1;
    logic [15:0] dividend_i = '0;
    logic [15:0] divisor_i = '0;
    logic        signed_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] quotient_o, remainder_o;
    logic        divide_by_zero_o, overflow_o, data_valid_o;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    non_restoring_divider_mc #(.DATA_WIDTH(16), .BITS_PER_CYCLE(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .clk_en_i         (clk_en_i),
        .dividend_i       (dividend_i),
        .divisor_i        (divisor_i),
        .signed_i         (signed_i),
        .data_valid_i     (data_valid_i),
        .ready_o          (ready_o),
        .quotient_o       (quotient_o),
        .remainder_o      (remainder_o),
        .divide_by_zero_o (divide_by_zero_o),
        .overflow_o       (overflow_o),
        .data_valid_o     (data_valid_o)
    );

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t e;
        int   sa, sb_;
        e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 10; e.q = '0; e.r = '0;
        if (b == 16'h0) begin
            e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1; e.lat = 2;
        end
`ifdef NR_DIVIDER_SIGNED_EN
        else if (s && a == 16'h8000 && b == 16'hFFFF) begin
            e.q = 16'h8000; e.r = 16'h0; e.ovf = 1'b1; e.lat = 2;
        end else if (s) begin
            sa  = int'($signed(a));
            sb_ = int'($signed(b));
            e.q = 16'(sa / sb_);
            e.r = 16'(sa % sb_);
        end
`endif
        else begin
            sa  = int'(a) + int'(s) * 0;
            sb_ = int'(b);
            e.q = 16'(sa / sb_);
            e.r = 16'(sa % sb_);
        end
        return e;
    endfunction

    // Drive one request for the acceptance edge, then scramble operands so late sampling shows up.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clk);
        dividend_i = a; divisor_i = b; signed_i = s; data_valid_i = 1'b1;
        sb.push_back(model(a, b, s));
        @(posedge clk); #1;
        data_valid_i = 1'b0;
        dividend_i = 16'($urandom); divisor_i = 16'($urandom); signed_i = ~s;
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!data_valid_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ready_o, quotient_o, remainder_o, divide_by_zero_o, overflow_o, data_valid_o} !== {1'b1, 35'h0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b q=%h r=%h dbz=%b ovf=%b v=%b want rdy=1 rest 0",
                     ready_o, quotient_o, remainder_o, divide_by_zero_o, overflow_o, data_valid_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_unsigned;
        logic [15:0] tbl [6][2] = '{'{16'd100, 16'd7}, '{16'hFFFF, 16'd1}, '{16'hFFFF, 16'hFFFF},
                                    '{16'd5, 16'd10}, '{16'd0, 16'd3}, '{16'd50000, 16'd123}};
        int   lat;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            send(tbl[i][0], tbl[i][1], 1'b0);
            wait_valid(1, lat);
            e = sb.pop_front();
            total++;
            if (data_valid_o !== 1'b1 || lat != e.lat) begin
                bad++; $display("FAIL unsigned_lat[%0d] got %0d want %0d", i, lat, e.lat);
            end
            total++;
            if ({quotient_o, remainder_o, divide_by_zero_o, overflow_o} !== {e.q, e.r, e.dbz, e.ovf}) begin
                bad++;
                $display("FAIL unsigned[%0d] got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                         i, quotient_o, remainder_o, divide_by_zero_o, overflow_o, e.q, e.r, e.dbz, e.ovf);
            end
            if (i == 0) begin
                total++;
                if (ready_o !== 1'b1) begin
                    bad++; $display("FAIL ready_with_valid got %b want 1", ready_o);
                end
                @(posedge clk); #1;
                total++;
                if (data_valid_o !== 1'b0) begin
                    bad++; $display("FAIL valid_one_cycle got %b want 0", data_valid_o);
                end
            end
        end
    endtask

    task automatic test_signed;
        logic [15:0] tbl [6][2] = '{'{16'hFF9C, 16'h0007}, '{16'h0064, 16'hFFF9}, '{16'hFF9C, 16'hFFF9},
                                    '{16'h8000, 16'h0001}, '{16'h7FFF, 16'h8000}, '{16'h8001, 16'h0003}};
        int   lat;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            send(tbl[i % 6][0], tbl[i % 6][1], (i < 6));
            wait_valid(1, lat);
            e = sb.pop_front();
            total++;
            if (data_valid_o !== 1'b1 || lat != e.lat) begin
                bad++; $display("FAIL signed_lat[%0d] got %0d want %0d", i, lat, e.lat);
            end
            total++;
            if ({quotient_o, remainder_o, divide_by_zero_o, overflow_o} !== {e.q, e.r, e.dbz, e.ovf}) begin
                bad++;
                $display("FAIL signed[%0d] got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                         i, quotient_o, remainder_o, divide_by_zero_o, overflow_o, e.q, e.r, e.dbz, e.ovf);
            end
        end
    endtask

    task automatic test_special;
        logic [15:0] tbl [4][2] = '{'{16'd1234, 16'h0}, '{16'h8000, 16'hFFFF}, '{16'h0, 16'h0}, '{16'hFF9C, 16'h0}};
        logic        sgn [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int   lat;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(tbl[i][0], tbl[i][1], sgn[i]);
            wait_valid(1, lat);
            e = sb.pop_front();
            total++;
            if (data_valid_o !== 1'b1 || lat != e.lat) begin
                bad++; $display("FAIL special_lat[%0d] got %0d want %0d", i, lat, e.lat);
            end
            total++;
            if ({quotient_o, remainder_o, divide_by_zero_o, overflow_o} !== {e.q, e.r, e.dbz, e.ovf}) begin
                bad++;
                $display("FAIL special[%0d] got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                         i, quotient_o, remainder_o, divide_by_zero_o, overflow_o, e.q, e.r, e.dbz, e.ovf);
            end
            if (i == 0) begin
                repeat (3) @(posedge clk);
                #1;
                total++;
                if ({quotient_o, remainder_o, divide_by_zero_o} !== {e.q, e.r, e.dbz}) begin
                    bad++; $display("FAIL result_hold got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                                    quotient_o, remainder_o, divide_by_zero_o, e.q, e.r, e.dbz);
                end
            end
        end
    endtask

    task automatic test_clk_en;
        int   lat;
        exp_t e;
        send(16'd100, 16'd7, 1'b0);
        lat = 1;
        repeat (2) begin @(posedge clk); #1; lat++; end
        clk_en_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        clk_en_i = 1'b1;
        wait_valid(lat, lat);
        e = sb.pop_front();
        total++;
        if (data_valid_o !== 1'b1 || lat != e.lat + 3) begin
            bad++; $display("FAIL clk_en_lat got %0d want %0d", lat, e.lat + 3);
        end
        total++;
        if ({quotient_o, remainder_o} !== {e.q, e.r}) begin
            bad++; $display("FAIL clk_en_result got q=%h r=%h want q=%h r=%h", quotient_o, remainder_o, e.q, e.r);
        end
    endtask

    task automatic test_mid_reset;
        bit saw_valid = 1'b0;
        exp_t e;
        send(16'd100, 16'd7, 1'b0);
        e = sb.pop_back();
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        clk_en_i = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({ready_o, quotient_o, remainder_o, divide_by_zero_o, overflow_o, data_valid_o} !== {1'b1, 35'h0}) begin
            bad++;
            $display("FAIL mid_reset got rdy=%b q=%h r=%h dbz=%b ovf=%b v=%b want rdy=1 rest 0 (dropped q=%h)",
                     ready_o, quotient_o, remainder_o, divide_by_zero_o, overflow_o, data_valid_o, e.q);
        end
        rst_i = 1'b0;
        clk_en_i = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (data_valid_o) saw_valid = 1'b1;
        end
        total++;
        if (saw_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_no_pulse got 1 want 0");
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [15:0] a, b;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom_range(1, 65535));
            dividend_i = a; divisor_i = b; signed_i = 1'b0; data_valid_i = 1'b1;
            if (c % 10 == 0) sb.push_back(model(a, b, 1'b0));
            @(posedge clk); #1;
            if (c == 39) data_valid_i = 1'b0;
            total++;
            if (data_valid_o !== (c % 10 == 9)) begin
                bad++; $display("FAIL b2b_valid[c=%0d] got %b want %b", c, data_valid_o, (c % 10 == 9));
            end
            if (data_valid_o === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({quotient_o, remainder_o} !== {e.q, e.r}) begin
                    bad++; $display("FAIL b2b_result[c=%0d] got q=%h r=%h want q=%h r=%h",
                                    c, quotient_o, remainder_o, e.q, e.r);
                end
            end
        end
        sb.delete();
    endtask

    task automatic test_random;
        int   lat;
        exp_t e;
        logic [15:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            b = (i % 7 == 3) ? 16'h0 : 16'($urandom >> ($urandom_range(0, 12)));
            if (i == 5) begin a = 16'h8000; b = 16'hFFFF; end
            send(a, b, 1'($urandom));
            wait_valid(1, lat);
            e = sb.pop_front();
            total++;
            if (data_valid_o !== 1'b1 || lat != e.lat ||
                {quotient_o, remainder_o, divide_by_zero_o, overflow_o} !== {e.q, e.r, e.dbz, e.ovf}) begin
                bad++;
                $display("FAIL random[%0d] %h/%h got lat=%0d q=%h r=%h dbz=%b ovf=%b want lat=%0d q=%h r=%h dbz=%b ovf=%b",
                         i, a, b, lat, quotient_o, remainder_o, divide_by_zero_o, overflow_o,
                         e.lat, e.q, e.r, e.dbz, e.ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_clk_en();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
